// File: rtl/fibo_result_fifo.sv
// Result FIFO behind the Fibonacci calculator: captures {count, data} on each done rise
// and presents entries first-word-fall-through. Optional drop statistics: FIBO_OVF_STAT_EN.
module fibo_result_fifo #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  count,
    input  logic              done,
    input  logic [DATA_W-1:0] data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              full,
    output logic              empty,
`ifdef FIBO_OVF_STAT_EN
    output logic              ovf,
    output logic [7:0]        drop_cnt,
`endif
    output logic [LVL_W-1:0]  level
);

    localparam int ENT_W = CNT_W + DATA_W;

    logic                 start_q, done_q;
    logic [CNT_W-1:0]     req_count_q, req_count_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [ENT_W-1:0]     mem_q [DEPTH];
    logic                 start_rise, done_rise, push, pop;

    always_comb begin
        start_rise  = start & ~start_q;
        done_rise   = done & ~done_q;
        empty       = (level_q == '0);
        full        = (level_q == LVL_W'(DEPTH));
        out_valid   = ~empty;
        pop         = out_valid & out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        push        = done_rise & (~full | pop);
        req_count_d = start_rise ? count : req_count_q;
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d     = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        level     = level_q;
        out_data  = mem_q[rd_ptr_q][DATA_W-1:0];
        out_count = mem_q[rd_ptr_q][ENT_W-1:DATA_W];
    end

    // Edge-detect registers reset high so a level already asserted at release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q     <= 1'b1;
            done_q      <= 1'b1;
            req_count_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            start_q     <= start;
            done_q      <= done;
            req_count_q <= req_count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (rst)
                    mem_q[gi] <= '0;
                else if (push && (wr_ptr_q == PTR_W'(gi)))
                    mem_q[gi] <= {req_count_q, data};
            end
        end
    endgenerate

`ifdef FIBO_OVF_STAT_EN
    logic       drop;
    logic       ovf_q, ovf_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop       = done_rise & full & ~pop;
        ovf_d      = ovf_q | drop;
        drop_cnt_d = (drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
        ovf        = ovf_q;
        drop_cnt   = drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_fibo_result_fifo.sv
// Directed plus randomized bench for fibo_result_fifo against a queue-based reference model.
module tb_fibo_result_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] count = '0;
    logic       done = 1'b0;
    logic [3:0] data = '0;
    logic       out_valid, out_ready = 1'b0;
    logic [3:0] out_data, out_count;
    logic       full, empty;
    logic [2:0] level;
`ifdef FIBO_OVF_STAT_EN
    logic       ovf;
    logic [7:0] drop_cnt;
`endif

    fibo_result_fifo #(.DATA_W(4), .CNT_W(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .count(count), .done(done), .data(data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .full(full), .empty(empty),
`ifdef FIBO_OVF_STAT_EN
        .ovf(ovf), .drop_cnt(drop_cnt),
`endif
        .level(level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of {count, data} pairs plus last requested count.
    logic [7:0] mq[$];
    logic [3:0] m_req = '0;
    logic       m_prev_start = 1'b1, m_prev_done = 1'b1;
    int         m_drops = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("level", 32'(level), 32'(mq.size()));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        if (mq.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(mq[0][3:0]));
            chk("out_count", 32'(out_count), 32'(mq[0][7:4]));
        end
`ifdef FIBO_OVF_STAT_EN
        chk("ovf", 32'(ovf), 32'(m_drops != 0));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drops > 255 ? 255 : m_drops));
`endif
        $display("t=%0t rst=%0b start=%0b cnt=%0d done=%0b data=%0d rdy=%0b -> vld=%0b od=%0d oc=%0d lvl=%0d",
                 $time, rst, start, count, done, data, out_ready, out_valid, out_data, out_count, level);
    endtask

    // One clock: evaluate the model on pre-edge inputs, then compare #1 after the edge.
    task automatic step();
        bit         d_rise, s_rise, do_pop, do_push;
        logic [7:0] ent;
        d_rise  = done && !m_prev_done;
        s_rise  = start && !m_prev_start;
        do_pop  = out_ready && (mq.size() != 0);
        do_push = d_rise && ((mq.size() < DEPTH) || do_pop);
        ent     = {m_req, data};
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            m_req = '0;
            m_prev_start = 1'b1;
            m_prev_done = 1'b1;
            m_drops = 0;
        end else begin
            if (d_rise && !do_push) m_drops++;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(ent);
            if (s_rise) m_req = count;
            m_prev_start = start;
            m_prev_done = done;
        end
        check_outputs();
    endtask

    task automatic push_val(input logic [3:0] d);
        data = d; done = 1'b1; step();
        done = 1'b0; step();
    endtask

    task automatic request(input logic [3:0] c);
        count = c; start = 1'b1; step();
        start = 1'b0; step();
    endtask

    initial begin
        // 1: reset with done/start high at release -> no push
        rst = 1'b1; done = 1'b1; start = 1'b1;
        step(); step();
        rst = 1'b0;
        step(); step();
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_valid", 32'(out_valid), 32'd0);
        chk("t1_out_data", 32'(out_data), 32'd0);
        chk("t1_out_count", 32'(out_count), 32'd0);
        done = 1'b0; start = 1'b0; step();

        // 2: single result with its count
        request(4'd7);
        data = 4'd13; done = 1'b1; step();
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_data", 32'(out_data), 32'd13);
        chk("t2_count", 32'(out_count), 32'd7);
        done = 1'b0; out_ready = 1'b1; step();
        out_ready = 1'b0;
        chk("t2_empty", 32'(empty), 32'd1);

        // 3: fill, drop fifth, drain in order
        push_val(4'd1); push_val(4'd2); push_val(4'd3); push_val(4'd5);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_level", 32'(level), 32'd4);
        push_val(4'd8);
        chk("t3_level_after_drop", 32'(level), 32'd4);
`ifdef FIBO_OVF_STAT_EN
        chk("t3_ovf", 32'(ovf), 32'd1);
        chk("t3_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
        foreach (mq[i]) chk("t3_model_order", 32'(mq[i][3:0]), (i == 3) ? 32'd5 : 32'(i + 1));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b0;
        chk("t3_drained", 32'(empty), 32'd1);

        // 4: full + push + pop same cycle
        push_val(4'd1); push_val(4'd2); push_val(4'd3); push_val(4'd5);
        data = 4'd8; done = 1'b1; out_ready = 1'b1; step();
        done = 1'b0; out_ready = 1'b0; step();
        chk("t4_level", 32'(level), 32'd4);
        chk("t4_head", 32'(out_data), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_drain", 32'(out_data), (i == 3) ? 32'd8 : ((i == 2) ? 32'd5 : 32'(i + 2)));
            step();
        end
        out_ready = 1'b0;

        // 5: done held high -> one push; last start wins
        data = 4'd9; done = 1'b1;
        for (int i = 0; i < 10; i++) step();
        done = 1'b0; step();
        chk("t5_level_one", 32'(level), 32'd1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        request(4'd5); request(4'd6);
        push_val(4'd4);
        chk("t5_last_count", 32'(out_count), 32'd6);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // 6: reset mid-run drops everything
        push_val(4'd1); push_val(4'd2); push_val(4'd3);
        chk("t6_level3", 32'(level), 32'd3);
        rst = 1'b1; step(); rst = 1'b0;
        chk("t6_level0", 32'(level), 32'd0);
        chk("t6_valid0", 32'(out_valid), 32'd0);
        step();
        request(4'd11);
        push_val(4'd10);
        chk("t6_repush_data", 32'(out_data), 32'd10);
        chk("t6_repush_count", 32'(out_count), 32'd11);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 79) == 0);
            start     = $urandom_range(0, 1);
            count     = 4'($urandom);
            done      = $urandom_range(0, 1);
            data      = 4'($urandom);
            out_ready = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
